branch_redirect_unit: RTL
=========================

// Module: branch_redirect_unit
// PURPOSE
//   Consumes the taken/not-taken result of the decode-stage branch condition evaluator and
//   turns it into a registered PC redirect request toward instruction fetch.
//   Computes branch and jump targets, holds the redirect until fetch accepts it and
//   backpressures decode meanwhile. Keeps saturating branch/taken counters for perf monitoring.
// PARAMETERS
//   N          32  datapath/PC width in bits
//   CW         16  width of each performance counter
//   DELAY_SLOT  1  1: MIPS delay slot executes (no IF squash); 0: IF instruction squashed
// PORTS
//   clk            in   1   core clock, rising edge
//   rst_n          in   1   asynchronous active-low reset
//   id_valid       in   1   decode holds a valid instruction
//   id_stall       in   1   decode stalled this cycle (operands not ready); no evaluation
//   id_is_branch   in   1   instruction is a conditional branch
//   id_is_jump     in   1   instruction is J/JAL (absolute target)
//   id_is_jr       in   1   instruction is JR/JALR (register target)
//   bcres          in   1   branch condition result from the condition evaluator
//   id_pc          in   N   PC of the decode-stage instruction
//   id_imm16       in   16  branch offset, instruction words, signed
//   id_jidx        in   26  jump index field
//   id_rs_val      in   N   forwarded rs value (JR/JALR target)
//   flush_in       in   1   synchronous pipeline flush (exception/eret)
//   if_ready       in   1   fetch accepts redirect this cycle
//   redirect_valid out  1   redirect request pending
//   redirect_pc    out  N   redirect target PC
//   squash_if      out  1   instruction currently in IF is wrong-path
//   busy           out  1   unit cannot accept a new branch; decode must stall
//   br_count       out  CW  evaluated control-transfer count, saturating
//   taken_count    out  CW  taken count, saturating
// BEHAVIOUR
//   - Reset (rst_n=0, async): state IDLE; redirect_valid=0, redirect_pc=0, squash_if=0,
//     busy=0, br_count=0, taken_count=0. Reset mid-redirect drops the request.
//   - eval = id_valid & ~id_stall & ~busy & ~flush_in & (id_is_branch|id_is_jump|id_is_jr).
//     At most one of id_is_branch/id_is_jump/id_is_jr is high; otherwise undefined.
//   - taken = id_is_jump | id_is_jr | (id_is_branch & bcres).
//   - Targets, all modulo 2^N (wrap silently):
//     branch: id_pc + 4 + (sext(id_imm16) << 2)
//     jump:   {pc4[N-1:28], id_jidx, 2'b00}, pc4 = id_pc + 4
//     jr:     id_rs_val (no alignment check)
//   - FSM, two states:
//     IDLE: eval & taken -> latch target into redirect_pc, go HOLD (latency 1: redirect_valid
//           high the cycle after eval). eval & ~taken -> stay IDLE, no redirect.
//     HOLD: redirect_valid=1, busy=1. if_ready=1 at clock edge -> IDLE (handshake complete;
//           redirect_valid low next cycle). if_ready=0 -> stay, redirect_pc stable.
//   - Fetch may assert if_ready combinationally from redirect_valid; no timeout.
//   - busy = (state==HOLD). Branches presented while busy are ignored (not counted);
//     decode must not advance while busy.
//   - squash_if = redirect_valid & (DELAY_SLOT==0); constant 0 when DELAY_SLOT=1.
//   - flush_in=1: next state IDLE, pending redirect dropped, no evaluation that cycle;
//     flush beats a simultaneous if_ready. Counters are not cleared by flush.
//   - Counters: on eval, br_count+=1; if taken, taken_count+=1; both hold at 2^CW-1.
//   - No combinational path from inputs to redirect_valid/redirect_pc; busy, squash_if
//     depend only on state.
// TESTING
//   1. BEQ, bcres=1, id_pc=0x0040_0010, imm16=0x0004, if_ready=1 -> next cycle
//      redirect_valid=1, redirect_pc=0x0040_0024; then IDLE; taken_count=1.
//   2. BNE, bcres=0 -> no redirect_valid; br_count+1, taken_count unchanged.
//   3. J, id_pc=0x8000_0000, jidx=0x000_0100, if_ready=0 for 3 cycles -> redirect_pc=0x8000_0400
//      held stable, busy=1 for 4 cycles, second branch presented meanwhile not counted.
//   4. imm16=0x8000 at id_pc=0x0000_0004 -> redirect_pc=0xFFFE_0008 (wrap).
//   5. flush_in during HOLD with if_ready=1 -> redirect_valid=0 next cycle; rst_n low
//      mid-HOLD -> all outputs 0 immediately.
//   6. CW=4: 17 taken jumps -> both counters stop at 15; DELAY_SLOT=0 -> squash_if
//      mirrors redirect_valid.

Source files
------------

// File: rtl/branch_redirect_unit.sv
// Decode-stage branch redirect unit: turns an evaluated control transfer into a
// registered fetch redirect, holds it until fetch accepts, and keeps saturating perf counters.
module branch_redirect_unit #(
  parameter int N          = 32,
  parameter int CW         = 16,
  parameter int DELAY_SLOT = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          id_valid,
  input  logic          id_stall,
  input  logic          id_is_branch,
  input  logic          id_is_jump,
  input  logic          id_is_jr,
  input  logic          bcres,
  input  logic [N-1:0]  id_pc,
  input  logic [15:0]   id_imm16,
  input  logic [25:0]   id_jidx,
  input  logic [N-1:0]  id_rs_val,
  input  logic          flush_in,
  input  logic          if_ready,
  output logic          redirect_valid,
  output logic [N-1:0]  redirect_pc,
  output logic          squash_if,
  output logic          busy,
  output logic [CW-1:0] br_count,
  output logic [CW-1:0] taken_count
);

  typedef enum logic {IDLE, HOLD} state_t;

  localparam logic [CW-1:0] CNT_MAX = '1;

  state_t       state_reg, state_next;
  logic [N-1:0] redirect_pc_reg;
  logic [CW-1:0] br_count_reg, taken_count_reg;

  logic         eval, taken;
  logic [N-1:0] pc4, br_target, jmp_target, target;

  assign pc4        = id_pc + N'(4);
  assign br_target  = pc4 + {{(N-18){id_imm16[15]}}, id_imm16, 2'b00};
  assign jmp_target = {pc4[N-1:28], id_jidx, 2'b00};
  assign target     = id_is_jr ? id_rs_val : (id_is_jump ? jmp_target : br_target);

  assign eval  = id_valid & ~id_stall & ~busy & ~flush_in &
                 (id_is_branch | id_is_jump | id_is_jr);
  assign taken = id_is_jump | id_is_jr | (id_is_branch & bcres);

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (eval && taken) state_next = HOLD;
      HOLD:    if (if_ready)      state_next = IDLE;
      default: state_next = IDLE;
    endcase
    // A flush always wins, even over an accepting fetch stage
    if (flush_in) state_next = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= IDLE;
      redirect_pc_reg <= '0;
      br_count_reg    <= '0;
      taken_count_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (eval && taken) redirect_pc_reg <= target;
      if (eval) begin
        if (br_count_reg != CNT_MAX) br_count_reg <= br_count_reg + 1'b1;
        if (taken && taken_count_reg != CNT_MAX) taken_count_reg <= taken_count_reg + 1'b1;
      end
    end
  end

  assign redirect_valid = (state_reg == HOLD);
  assign busy           = (state_reg == HOLD);
  assign squash_if      = (DELAY_SLOT == 0) && (state_reg == HOLD);
  assign redirect_pc    = redirect_pc_reg;
  assign br_count       = br_count_reg;
  assign taken_count    = taken_count_reg;

endmodule
